multicycle_datapath: RTL and testbench

//   Parametrised multi-cycle successor of the single-cycle board datapath: 16 regs, data RAM, add/sub ALU, beq.
//   FSM sequences FETCH/DECODE/EXEC/MEM/WB over a synchronous-read instruction ROM.

---
 rtl/multicycle_datapath.sv | 244 ++++++++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
// rtl/multicycle_datapath.sv - multi-cycle 16-register datapath with ROM fetch, injection and debug port
//
// Purpose:
//   Sequences FETCH/DECODE/EXEC/MEM/WB over a synchronous-read instruction ROM.
//   Instructions are issued from IDLE in one of three ways, in priority order:
//   injected from switches, single-stepped, or free-running.
//   The datapath has a 16-entry register file, a data RAM and an add/sub ALU,
//   and supports a beq branch.
//
// Ports:
//   i_clk         rising-edge clock
//   i_reset       synchronous active-high reset
//   o_imem_addr   registered ROM address (tracks the program counter)
//   i_imem_data   ROM word, valid the cycle after o_imem_addr changes
//   i_run_en      level: issue instructions back-to-back
//   i_step        pulse: issue one instruction from IDLE
//   i_inj_valid   injected instruction offered
//   i_inj_instr   injected instruction word
//   o_inj_ready   high in the IDLE cycle an injected instruction is taken
//   o_busy        high whenever the FSM is not IDLE
//   o_retire      one-cycle pulse in the last state of each instruction
//   o_pc          program counter
//   o_ir          instruction register
//   o_zero        zero flag of the last ADD/SUB result
//   i_dbg_sel     debug source: 0 register file, 1 data memory
//   i_dbg_addr    debug read address
//   o_dbg_data    registered debug read data
module multicycle_datapath #(
   parameter int DATA_W = 8,
   parameter int PC_W   = 5,
   parameter int DMEM_D = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   output logic [PC_W-1:0]   o_imem_addr,
   input  logic [15:0]       i_imem_data,
   input  logic              i_run_en,
   input  logic              i_step,
   input  logic              i_inj_valid,
   input  logic [15:0]       i_inj_instr,
   output logic              o_inj_ready,
   output logic              o_busy,
   output logic              o_retire,
   output logic [PC_W-1:0]   o_pc,
   output logic [15:0]       o_ir,
   output logic              o_zero,
   input  logic              i_dbg_sel,
   input  logic [3:0]        i_dbg_addr,
   output logic [DATA_W-1:0] o_dbg_data
);

   localparam int DA_W = (DMEM_D > 1) ? $clog2(DMEM_D) : 1;

   localparam logic [2:0] OP_LOADI  = 3'd0;
   localparam logic [2:0] OP_LOAD   = 3'd1;
   localparam logic [2:0] OP_STORE  = 3'd2;
   localparam logic [2:0] OP_ADD    = 3'd3;
   localparam logic [2:0] OP_SUB    = 3'd4;
   localparam logic [2:0] OP_BEQ    = 3'd5;
   localparam logic [2:0] OP_STOREI = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [DATA_W-1:0] r_regs [16];
   logic [DATA_W-1:0] r_mem  [DMEM_D];
   logic [15:0]       r_ir;
   logic [PC_W-1:0]   r_pc;
   logic [PC_W-1:0]   r_imem_addr;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [DATA_W-1:0] r_alu;
   logic [DATA_W-1:0] r_mdr;
   logic [DATA_W-1:0] r_dbg;
   logic              r_zero;
   logic              r_inj;       // current instruction was injected, not fetched
   logic              r_run_mode;  // current instruction was issued by run_en

   logic [2:0]        w_op;
   logic [3:0]        w_rd;
   logic [3:0]        w_ra;
   logic [3:0]        w_rb;
   logic [DATA_W-1:0] w_imm;
   logic [PC_W-1:0]   w_tgt;
   logic [DATA_W-1:0] w_sum;
   logic [DATA_W-1:0] w_diff;
   logic              w_last;
   logic              w_cont;
   logic              w_take;
   logic              w_taken;
   logic [PC_W-1:0]   w_pc_next;

   // RAM addresses are 4-bit fields folded onto the configured depth.
   function automatic logic [DA_W-1:0] f_maddr(input logic [3:0] a);
      return DA_W'(32'(a) % DMEM_D);
   endfunction

   assign w_op   = r_ir[15:13];
   assign w_rd   = r_ir[11:8];
   assign w_ra   = r_ir[7:4];
   assign w_rb   = r_ir[3:0];
   assign w_imm  = DATA_W'(r_ir[7:0]);
   assign w_tgt  = r_ir[8 +: PC_W];
   assign w_sum  = r_a + r_b;
   assign w_diff = r_a - r_b;
   assign w_cont = r_run_mode && i_run_en;
   assign w_taken = (r_state == S_EXEC) && (w_op == OP_BEQ) && (r_a == r_b);

   // Next-state and control outputs
   always_comb begin
      w_state_next = r_state;
      w_last       = 1'b0;
      w_take       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_inj_valid) begin
               w_take       = 1'b1;
               w_state_next = S_DECODE;
            end else if (i_step || i_run_en) begin
               w_state_next = S_FETCH;
            end
         end
         S_FETCH:  w_state_next = S_DECODE;
         S_DECODE: w_state_next = S_EXEC;
         S_EXEC: begin
            case (w_op)
               OP_LOADI, OP_ADD, OP_SUB:      w_state_next = S_WB;
               OP_LOAD, OP_STORE, OP_STOREI:  w_state_next = S_MEM;
               default: begin
                  w_last       = 1'b1;
                  w_state_next = w_cont ? S_FETCH : S_IDLE;
               end
            endcase
         end
         S_MEM: begin
            if (w_op == OP_LOAD) begin
               w_state_next = S_WB;
            end else begin
               w_last       = 1'b1;
               w_state_next = w_cont ? S_FETCH : S_IDLE;
            end
         end
         S_WB: begin
            w_last       = 1'b1;
            w_state_next = w_cont ? S_FETCH : S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_next;
   end

   // A taken branch overrides the sequential increment; injected
   // instructions do not advance the pc.
   always_comb begin
      w_pc_next = r_pc;
      if (w_last) begin
         if (w_taken)     w_pc_next = w_tgt;
         else if (!r_inj) w_pc_next = r_pc + PC_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ir        <= '0;
         r_pc        <= '0;
         r_imem_addr <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_alu       <= '0;
         r_mdr       <= '0;
         r_dbg       <= '0;
         r_zero      <= 1'b0;
         r_inj       <= 1'b0;
         r_run_mode  <= 1'b0;
         for (int i = 0; i < 16; i++)     r_regs[i] <= '0;
         for (int i = 0; i < DMEM_D; i++) r_mem[i]  <= '0;
      end else begin
         // Nonblocking read: a write to the same location this cycle shows next time.
         r_dbg       <= i_dbg_sel ? r_mem[f_maddr(i_dbg_addr)] : r_regs[i_dbg_addr];
         r_pc        <= w_pc_next;
         r_imem_addr <= w_pc_next;
         case (r_state)
            S_IDLE: begin
               if (i_inj_valid) begin
                  r_ir       <= i_inj_instr;
                  r_inj      <= 1'b1;
                  r_run_mode <= 1'b0;
               end else if (i_step || i_run_en) begin
                  r_inj      <= 1'b0;
                  r_run_mode <= !i_step;
               end
            end
            S_FETCH:  r_ir <= i_imem_data;
            S_DECODE: begin
               r_a <= r_regs[w_ra];
               r_b <= r_regs[w_rb];
            end
            S_EXEC: begin
               if (w_op == OP_ADD) begin
                  r_alu  <= w_sum;
                  r_zero <= (w_sum == '0);
               end else if (w_op == OP_SUB) begin
                  r_alu  <= w_diff;
                  r_zero <= (w_diff == '0);
               end
            end
            S_MEM: begin
               case (w_op)
                  OP_LOAD:   r_mdr <= r_mem[f_maddr(w_ra)];
                  OP_STORE:  r_mem[f_maddr(w_rd)] <= r_a;
                  OP_STOREI: r_mem[f_maddr(w_rd)] <= w_imm;
                  default:   ;
               endcase
            end
            S_WB: begin
               case (w_op)
                  OP_LOADI: r_regs[w_rd] <= w_imm;
                  OP_LOAD:  r_regs[w_rd] <= r_mdr;
                  default:  r_regs[w_rd] <= r_alu;
               endcase
            end
            default: ;
         endcase
      end
   end

   assign o_imem_addr = r_imem_addr;
   assign o_inj_ready = w_take && !i_reset;
   assign o_busy      = (r_state != S_IDLE);
   assign o_retire    = w_last && !i_reset;
   assign o_pc        = r_pc;
   assign o_ir        = r_ir;
   assign o_zero      = r_zero;
   assign o_dbg_data  = r_dbg;

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb/tb_multicycle_datapath.sv - directed scoreboard bench for multicycle_datapath
module tb_multicycle_datapath;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  imem_addr;
   logic [15:0] imem_data;
   logic        run_en, step, inj_valid, inj_ready, busy, retire, zero, dbg_sel;
   logic [15:0] inj_instr, ir;
   logic [4:0]  pc;
   logic [3:0]  dbg_addr;
   logic [7:0]  dbg_data;

   logic [15:0] rom [32];
   assign imem_data = rom[imem_addr];

   always #5 clk = ~clk;

   multicycle_datapath #(.DATA_W(8), .PC_W(5), .DMEM_D(16)) dut (
      .i_clk(clk), .i_reset(reset), .o_imem_addr(imem_addr), .i_imem_data(imem_data),
      .i_run_en(run_en), .i_step(step), .i_inj_valid(inj_valid), .i_inj_instr(inj_instr),
      .o_inj_ready(inj_ready), .o_busy(busy), .o_retire(retire), .o_pc(pc), .o_ir(ir),
      .o_zero(zero), .i_dbg_sel(dbg_sel), .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int n_ret  = 0;
   int n_rdy  = 0;

   typedef struct {
      string      tag;
      logic       sel;
      logic [3:0] addr;
      logic [7:0] val;
   } sb_t;
   sb_t sb [$];

   always @(negedge clk) begin
      if (retire)    n_ret++;
      if (inj_ready) n_rdy++;
   end

   function automatic logic [15:0] rrr(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb);
      return {op, 1'b0, rd, ra, rb};
   endfunction

   function automatic logic [15:0] rim(input logic [2:0] op, input logic [3:0] rd, input logic [7:0] imm);
      return {op, 1'b0, rd, imm};
   endfunction

   function automatic logic [15:0] beq(input logic [4:0] tgt, input logic [3:0] ra, input logic [3:0] rb);
      return {3'b101, tgt, ra, rb};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic push(input string tag, input logic sel, input logic [3:0] a, input logic [7:0] v);
      sb_t e;
      e.tag = tag; e.sel = sel; e.addr = a; e.val = v;
      sb.push_back(e);
   endtask

   task automatic drain;
      sb_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         dbg_sel  = e.sel;
         dbg_addr = e.addr;
         @(posedge clk);
         tick;
         chk(e.tag, 32'(dbg_data), 32'(e.val));
      end
   endtask

   // Waits (bounded) for retire, returns cycles counted from the cycle after issue,
   // then steps one more cycle so the DUT is back in IDLE.
   task automatic wait_retire(input string tag, output int lat);
      bit got;
      got = 1'b0;
      lat = 0;
      for (int k = 1; k <= 20 && !got; k++) begin
         tick;
         if (retire) begin
            got = 1'b1;
            lat = k;
         end
      end
      chk({tag, "_retired"}, 32'(got), 32'd1);
      tick;
   endtask

   task automatic inject(input string tag, input logic [15:0] ins, output int lat);
      inj_valid = 1'b1;
      inj_instr = ins;
      #1;
      chk({tag, "_inj_ready"}, 32'(inj_ready), 32'd1);
      @(posedge clk);
      #1 inj_valid = 1'b0;
      wait_retire(tag, lat);
   endtask

   task automatic step_one(input string tag, output int lat);
      step = 1'b1;
      @(posedge clk);
      #1 step = 1'b0;
      wait_retire(tag, lat);
   endtask

   int lat, r0, rdy0, c1, c2, nr;

   initial begin
      #500000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 32; i++) rom[i] = 16'hE000;
      reset = 1'b1; run_en = 1'b0; step = 1'b0; inj_valid = 1'b0;
      inj_instr = 16'h0; dbg_sel = 1'b0; dbg_addr = 4'h0;
      repeat (3) tick;
      reset = 1'b0;
      #1;
      chk("rst_pc", 32'(pc), 0);
      chk("rst_imem_addr", 32'(imem_addr), 0);
      chk("rst_ir", 32'(ir), 0);
      chk("rst_zero", 32'(zero), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_retire", 32'(retire), 0);
      chk("rst_dbg", 32'(dbg_data), 0);
      tick;

      // Injected arithmetic
      r0 = n_ret;
      inject("ld_r1", rim(3'd0, 4'd1, 8'h05), lat);
      chk("inj_loadi_latency", 32'(lat), 3);
      push("reg1", 1'b0, 4'd1, 8'h05);
      inject("ld_r2", rim(3'd0, 4'd2, 8'h03), lat);
      push("reg2", 1'b0, 4'd2, 8'h03);
      inject("sub_r3", rrr(3'd4, 4'd3, 4'd1, 4'd2), lat);
      push("reg3", 1'b0, 4'd3, 8'h02);
      chk("sub_r3_zero", 32'(zero), 0);
      chk("inj_pc_unchanged", 32'(pc), 0);
      chk("three_retires", 32'(n_ret - r0), 3);
      drain();

      inject("sub_r4", rrr(3'd4, 4'd4, 4'd2, 4'd1), lat);
      chk("sub_r4_zero", 32'(zero), 0);
      push("reg4_wrap", 1'b0, 4'd4, 8'hFE);
      inject("sub_r5", rrr(3'd4, 4'd5, 4'd1, 4'd1), lat);
      chk("sub_r5_zero", 32'(zero), 1);
      push("reg5", 1'b0, 4'd5, 8'h00);
      inject("add_r8", rrr(3'd3, 4'd8, 4'd4, 4'd2), lat);
      chk("add_r8_zero", 32'(zero), 0);
      push("reg8_add_wrap", 1'b0, 4'd8, 8'h01);
      drain();

      // Free-run from ROM: STOREI (4 cycles) then LOAD (5 cycles), no bubble
      rom[0] = rim(3'd6, 4'd7, 8'hA5);
      rom[1] = rrr(3'd1, 4'd6, 4'd7, 4'd0);
      c1 = 0; c2 = 0; nr = 0;
      run_en = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick;
         if (retire) begin
            nr++;
            if (nr == 1) c1 = c;
            if (nr == 2) c2 = c;
         end
         if (c == 9) run_en = 1'b0;
      end
      chk("run_first_retire_cycle", 32'(c1), 4);
      chk("run_second_retire_cycle", 32'(c2), 9);
      chk("run_retire_count", 32'(nr), 2);
      chk("run_pc", 32'(pc), 2);
      chk("run_idle", 32'(busy), 0);
      push("mem7", 1'b1, 4'd7, 8'hA5);
      push("reg6", 1'b0, 4'd6, 8'hA5);
      drain();

      // Branches at the top of the pc range
      inject("inj_beq_to31", beq(5'd31, 4'd0, 4'd0), lat);
      chk("inj_beq_pc", 32'(pc), 31);
      rom[31] = beq(5'd2, 4'd1, 4'd1);
      step_one("beq_taken", lat);
      chk("beq_step_latency", 32'(lat), 3);
      chk("beq_taken_pc", 32'(pc), 2);
      inject("inj_beq_to31b", beq(5'd31, 4'd0, 4'd0), lat);
      rom[31] = beq(5'd2, 4'd1, 4'd2);
      step_one("beq_not_taken", lat);
      chk("beq_wrap_pc", 32'(pc), 0);

      // step held and inj_valid offered while busy
      rom[0] = rim(3'd6, 4'd8, 8'h5A);
      r0 = n_ret; rdy0 = n_rdy;
      step = 1'b1;
      tick;
      inj_valid = 1'b1;
      inj_instr = rim(3'd0, 4'd9, 8'h77);
      tick;
      tick;
      step = 1'b0;
      inj_valid = 1'b0;
      repeat (8) tick;
      chk("held_step_one_retire", 32'(n_ret - r0), 1);
      chk("busy_inj_ready_never", 32'(n_rdy - rdy0), 0);
      chk("held_step_pc", 32'(pc), 1);
      push("mem8", 1'b1, 4'd8, 8'h5A);
      push("reg9_not_injected", 1'b0, 4'd9, 8'h00);
      drain();

      // Reset landing in the MEM state of a STORE
      inject("ld_r7", rim(3'd0, 4'd7, 8'h3C), lat);
      push("reg7", 1'b0, 4'd7, 8'h3C);
      drain();
      inj_valid = 1'b1;
      inj_instr = rrr(3'd2, 4'd9, 4'd7, 4'd0);
      @(posedge clk);
      #1 inj_valid = 1'b0;
      tick;
      tick;
      tick;
      chk("store_in_mem_busy", 32'(busy), 1);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_pc", 32'(pc), 0);
      chk("abort_retire", 32'(retire), 0);
      tick;
      push("mem9_unwritten", 1'b1, 4'd9, 8'h00);
      push("reg7_cleared", 1'b0, 4'd7, 8'h00);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
